// File: rtl/turbo_enc_pkg.sv
// Shared types and constants for the rate-1/3 turbo encoder core.
package turbo_enc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      TAIL1 = 2'd2,
      TAIL2 = 2'd3
   } state_e;

   localparam int TAIL_LEN = 3;
   localparam int KMIN_LTE = 40;
   localparam int KMAX_LTE = 6144;

endpackage

// File: rtl/rsc_constituent.sv
// 8-state RSC constituent encoder, g0 = 1+D^2+D^3, g1 = 1+D+D^3.
// term forces the input to cancel the feedback so the register drains to 000.
module rsc_constituent (
   input  logic       clk,
   input  logic       aclr,
   input  logic       en,
   input  logic       term,
   input  logic       u,
   output logic       x,
   output logic       z,
   output logic [2:0] state
);

   logic [2:0] q_q;
   logic [2:0] q_d;
   logic       fb;

   always_comb begin
      x   = term ? (q_q[1] ^ q_q[2]) : u;
      fb  = x ^ q_q[1] ^ q_q[2];
      z   = fb ^ q_q[0] ^ q_q[2];
      q_d = en ? {q_q[1], q_q[0], fb} : q_q;
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) q_q <= '0;
      else      q_q <= q_d;
   end

   assign state = q_q;

endmodule

// File: rtl/turbo_encoder_core.sv
// LTE rate-1/3 turbo encoder: two RSC encoders, runtime K, 12 tail bits.
// Optional debug outputs are enabled with TURBO_ENC_DEBUG_EN.
module turbo_encoder_core
   import turbo_enc_pkg::*;
#(
   parameter int KMAX  = KMAX_LTE,
   parameter int KMIN  = KMIN_LTE,
   parameter int CNT_W = $clog2(KMAX + 1)
) (
   input  logic             clk,
   input  logic             aclr,
   input  logic             start,
   input  logic [CNT_W-1:0] k_len,
   input  logic             ck,
   input  logic             cki,
   output logic             sys,
   output logic             par1,
   output logic             par2,
   output logic             out_valid,
   output logic             tail,
   output logic             tail_sel,
   output logic             busy,
   output logic             done,
   output logic             start_err
`ifdef TURBO_ENC_DEBUG_EN
   ,
   output logic [1:0]       dbg_state,
   output logic [CNT_W-1:0] dbg_cnt,
   output logic [2:0]       dbg_q1,
   output logic [2:0]       dbg_q2
`endif
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] k_q, k_d;

   logic sys_q, sys_d, par1_q, par1_d, par2_q, par2_d;
   logic valid_q, valid_d, tail_q, tail_d, tsel_q, tsel_d;
   logic busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic       en1, term1, en2, term2;
   logic       x1, z1, x2, z2;
   logic [2:0] st1, st2;
   logic       k_ok, go, last_data, last_tail;

   assign k_ok      = (k_len >= CNT_W'(KMIN)) && (k_len <= CNT_W'(KMAX));
   // A start is only taken when fully idle; the done cycle still counts as busy.
   assign go        = start && (state_q == IDLE) && !busy_q && k_ok;
   assign last_data = (cnt_q == k_q - CNT_W'(1));
   assign last_tail = (cnt_q == CNT_W'(TAIL_LEN - 1));

   rsc_constituent u_enc1 (
      .clk   (clk),
      .aclr  (aclr),
      .en    (en1),
      .term  (term1),
      .u     (ck),
      .x     (x1),
      .z     (z1),
      .state (st1)
   );

   rsc_constituent u_enc2 (
      .clk   (clk),
      .aclr  (aclr),
      .en    (en2),
      .term  (term2),
      .u     (cki),
      .x     (x2),
      .z     (z2),
      .state (st2)
   );

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      unique case (state_q)
         IDLE: begin
            if (go) begin
               state_d = DATA;
               cnt_d   = '0;
               k_d     = k_len;
            end
         end
         DATA: begin
            if (last_data) begin
               state_d = TAIL1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         TAIL1: begin
            if (last_tail) begin
               state_d = TAIL2;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         TAIL2: begin
            if (last_tail) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      en1     = 1'b0;
      term1   = 1'b0;
      en2     = 1'b0;
      term2   = 1'b0;
      sys_d   = 1'b0;
      par1_d  = 1'b0;
      par2_d  = 1'b0;
      valid_d = 1'b0;
      tail_d  = 1'b0;
      tsel_d  = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         DATA: begin
            en1     = 1'b1;
            en2     = 1'b1;
            sys_d   = ck;
            par1_d  = z1;
            par2_d  = z2;
            valid_d = 1'b1;
         end
         TAIL1: begin
            en1     = 1'b1;
            term1   = 1'b1;
            sys_d   = x1;
            par1_d  = z1;
            valid_d = 1'b1;
            tail_d  = 1'b1;
         end
         TAIL2: begin
            en2     = 1'b1;
            term2   = 1'b1;
            sys_d   = x2;
            par2_d  = z2;
            valid_d = 1'b1;
            tail_d  = 1'b1;
            tsel_d  = 1'b1;
            done_d  = last_tail;
         end
         default: ;
      endcase
      busy_d = (state_d != IDLE) || done_d;
      err_d  = start && !go;
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         sys_q   <= 1'b0;
         par1_q  <= 1'b0;
         par2_q  <= 1'b0;
         valid_q <= 1'b0;
         tail_q  <= 1'b0;
         tsel_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sys_q   <= sys_d;
         par1_q  <= par1_d;
         par2_q  <= par2_d;
         valid_q <= valid_d;
         tail_q  <= tail_d;
         tsel_q  <= tsel_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign sys       = sys_q;
   assign par1      = par1_q;
   assign par2      = par2_q;
   assign out_valid = valid_q;
   assign tail      = tail_q;
   assign tail_sel  = tsel_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign start_err = err_q;

`ifdef TURBO_ENC_DEBUG_EN
   assign dbg_state = state_q;
   assign dbg_cnt   = cnt_q;
   assign dbg_q1    = st1;
   assign dbg_q2    = st2;
`else
   logic unused_st;
   assign unused_st = ^{st1, st2};
`endif

endmodule

// File: tb/tb_turbo_encoder_core.sv
// Scoreboard bench for turbo_encoder_core against a bit-level RSC model.
module tb_turbo_encoder_core;

   localparam int CNT_W = 13;

   logic             clk = 1'b0;
   logic             aclr, start, ck, cki;
   logic [CNT_W-1:0] k_len;
   logic             sys, par1, par2, out_valid, tail, tail_sel;
   logic             busy, done, start_err;

   typedef struct packed {
      logic sys;
      logic p1;
      logic p2;
      logic tl;
      logic ts;
      logic dn;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   int         valid_cnt = 0;
   int         err_pulses = 0;
   logic [2:0] m1, m2;

   always #5 clk = ~clk;

   turbo_encoder_core dut (
      .clk       (clk),
      .aclr      (aclr),
      .start     (start),
      .k_len     (k_len),
      .ck        (ck),
      .cki       (cki),
      .sys       (sys),
      .par1      (par1),
      .par2      (par2),
      .out_valid (out_valid),
      .tail      (tail),
      .tail_sel  (tail_sel),
      .busy      (busy),
      .done      (done),
      .start_err (start_err)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference constituent encoder, state vector {D^3, D^2, D}.
   task automatic enc_step(inout logic [2:0] q, input logic u,
                           input logic term, output logic x,
                           output logic z);
      logic a, fb;
      a  = term ? (q[1] ^ q[2]) : u;
      fb = a ^ q[1] ^ q[2];
      z  = fb ^ q[0] ^ q[2];
      x  = a;
      q  = {q[1], q[0], fb};
   endtask

   task automatic push(input logic s, input logic p1, input logic p2,
                       input logic tl, input logic ts, input logic dn);
      exp_t e;
      e.sys = s;
      e.p1  = p1;
      e.p2  = p2;
      e.tl  = tl;
      e.ts  = ts;
      e.dn  = dn;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!aclr) begin
         if (start_err) err_pulses++;
         if (done) check("done_with_valid", 32'(out_valid), 1);
         if (out_valid) begin
            valid_cnt++;
            if (sb.size() == 0) begin
               check("valid_unexpected", 32'(out_valid), 0);
            end else begin
               e = sb.pop_front();
               check("sys", 32'(sys), 32'(e.sys));
               check("par1", 32'(par1), 32'(e.p1));
               check("par2", 32'(par2), 32'(e.p2));
               check("tail", 32'(tail), 32'(e.tl));
               check("tail_sel", 32'(tail_sel), 32'(e.ts));
               check("done", 32'(done), 32'(e.dn));
            end
         end
      end
   end

   task automatic run_block(input int k, input int mode, input int inj_at,
                            input bit prestarted, input bit start_on_done,
                            input int next_k, input int abort_at);
      logic x1, z1, x2, z2, b, bi;
      int   base;
      bit   seen;
      m1        = '0;
      m2        = '0;
      valid_cnt = 0;
      base      = err_pulses;
      if (!prestarted) begin
         @(posedge clk);
         #1;
         start = 1'b1;
         k_len = CNT_W'(k);
      end
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         #1;
         start = (i == inj_at);
         if (i == abort_at) begin
            aclr = 1'b1;
            #1;
            check("abort_valid", 32'(out_valid), 0);
            check("abort_sys", 32'(sys), 0);
            check("abort_par1", 32'(par1), 0);
            check("abort_par2", 32'(par2), 0);
            check("abort_busy", 32'(busy), 0);
            check("abort_done", 32'(done), 0);
            sb.delete();
            #2;
            aclr = 1'b0;
            return;
         end
         case (mode)
            0: begin b = 1'b0; bi = 1'b0; end
            1: begin b = (i == 0); bi = 1'b0; end
            default: begin
               b  = 1'($urandom_range(1, 0));
               bi = 1'($urandom_range(1, 0));
            end
         endcase
         ck  = b;
         cki = bi;
         enc_step(m1, b, 1'b0, x1, z1);
         enc_step(m2, bi, 1'b0, x2, z2);
         push(b, z1, z2, 1'b0, 1'b0, 1'b0);
      end
      for (int j = 0; j < 3; j++) begin
         enc_step(m1, 1'b0, 1'b1, x1, z1);
         push(x1, z1, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      for (int j = 0; j < 3; j++) begin
         enc_step(m2, 1'b0, 1'b1, x2, z2);
         push(x2, 1'b0, z2, 1'b1, 1'b1, (j == 2));
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      ck    = 1'b1;
      cki   = 1'b1;
      seen  = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 1);
      check("busy_at_done", 32'(busy), 1);
      if (start_on_done) begin
         start = 1'b1;
         k_len = CNT_W'(next_k);
      end
      @(posedge clk);
      #1;
      if (!start_on_done) start = 1'b0;
      @(negedge clk);
      #1;
      check("busy_after_done", 32'(busy), 0);
      check("valid_count", 32'(valid_cnt), 32'(k + 6));
      check("sb_empty", 32'(sb.size()), 0);
      check("err_pulses", 32'(err_pulses - base),
            32'(int'(inj_at >= 0) + int'(start_on_done)));
   endtask

   task automatic bad_start(input int k);
      @(posedge clk);
      #1;
      start = 1'b1;
      k_len = CNT_W'(k);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("bad_k_err", 32'(start_err), 1);
      check("bad_k_busy", 32'(busy), 0);
      @(negedge clk);
      check("bad_k_err_clr", 32'(start_err), 0);
      check("bad_k_valid", 32'(out_valid), 0);
      check("bad_k_busy2", 32'(busy), 0);
   endtask

   initial begin
      int nd;
      aclr  = 1'b1;
      start = 1'b0;
      ck    = 1'b0;
      cki   = 1'b0;
      k_len = '0;
      #12;
      check("rst_sys", 32'(sys), 0);
      check("rst_par1", 32'(par1), 0);
      check("rst_par2", 32'(par2), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_tail", 32'(tail), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(start_err), 0);
      aclr = 1'b0;

      run_block(40, 0, -1, 1'b0, 1'b0, 0, -1);
      run_block(40, 1, -1, 1'b0, 1'b0, 0, -1);
      run_block(6144, 2, -1, 1'b0, 1'b0, 0, -1);

      bad_start(39);
      bad_start(6145);

      run_block(200, 2, 10, 1'b0, 1'b1, 40, -1);
      run_block(40, 2, -1, 1'b1, 1'b0, 0, -1);

      run_block(1056, 2, -1, 1'b0, 1'b0, 0, 20);
      nd = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("no_done_after_abort", 32'(nd), 0);
      check("idle_after_abort", 32'(busy), 0);
      run_block(40, 2, -1, 1'b0, 1'b0, 0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
